pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives instruction-memory requests. It selects the next PC from three sources, in priority order: reset vector, redirect target (branch/jump/trap), and sequential +4. It keeps `imem_req`/`imem_addr` stable across memory wait states and hands one fetched instruction at a time to decode through a single-entry output buffer with stall backpressure. It sits between the instruction memory and the decode stage.

## Interface
- `RESET_VEC`, default 32'h0000_0000: PC value after reset.
- `TRAP_VEC`, default 32'h0000_0100: PC loaded on a misaligned redirect (only when the feature is compiled in).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_target` in 32: new PC value.
- `stall` in 1: decode is not ready; the buffered instruction is held.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: fetch address; always equals the current PC register.
- `imem_ack` in 1: memory response valid (may arrive in the same cycle as the request).
- `imem_rdata` in 32: instruction word, valid when `imem_ack` is high.
- `if_valid` out 1: output buffer holds an instruction.
- `if_pc` out 32: PC of the buffered instruction.
- `if_instr` out 32: buffered instruction word.
- `misalign_trap` out 1: one-cycle pulse when a misaligned redirect is trapped.

## Operation
- State machine: IDLE, FETCH, DRAIN, HOLD.
- Consume: `if_valid` high and `stall` low in the same cycle.
- IDLE (entered on `rst`):
  - `imem_req`=0; goes to FETCH unconditionally on the next cycle.
- FETCH (`imem_req`=1):
  - `imem_ack` and no redirect: buffer ← {pc, `imem_rdata`}; `if_valid`←1; pc←pc+4; go to HOLD.
  - `imem_ack` and redirect: drop the data; pc←target; stay in FETCH.
  - No `imem_ack`, redirect: pend←target; go to DRAIN. pc stays unchanged so the address is stable.
  - Otherwise: stay in FETCH.
- DRAIN (`imem_req`=1, address = old pc):
  - On `imem_ack`: drop the data; pc←pend; go to FETCH.
  - A redirect in DRAIN overwrites pend, so the latest redirect wins.
  - Redirect together with `imem_ack`: pc←`redirect_target`.
- HOLD (`imem_req`=0):
  - Redirect: `if_valid`←0 (flush); pc←target; go to FETCH.
  - Else if consume: `if_valid`←0; go to FETCH.
  - Else: stay in HOLD with the buffer unchanged.
- Redirect always outranks consume and +4.
- Arithmetic is 32-bit unsigned; pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Reset values:
  - state=IDLE, pc=`RESET_VEC` (so `imem_addr`=`RESET_VEC`).
  - `imem_req`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `misalign_trap`=0, pend=0.
- `rst` has priority in every state: an in-flight request is abandoned and any late `imem_ack` in IDLE is ignored.

## Timing
- `imem_req` and `imem_addr` are decoded from registered state/pc; there is no combinational path from `imem_ack` to `imem_req`.
- Handshake rule: once `imem_req` is high, `imem_addr` is held until an `imem_ack` is sampled.
- Reset released at edge N: IDLE during N, `imem_req` high from N+1.
- Zero-wait memory: ack in the FETCH cycle → `if_valid` high the next cycle.
- Peak throughput: one instruction per 2 cycles (FETCH, HOLD).
- A redirect in FETCH without ack costs at least one extra drained response.
- `misalign_trap` is registered and pulses in the cycle after the offending redirect.

## Configuration
- Macro: `PC_FETCH_MISALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_target[1:0]` ≠ 0 loads `TRAP_VEC` in place of the target, and `misalign_trap` pulses for one cycle.
- Undefined: `redirect_target[1:0]` is forced to 2'b00 before use; `misalign_trap` is tied to 0.

## Structure
- Package `pc_fetch_pkg`: state enum, `INSTR_BYTES`=4, default `RESET_VEC`/`TRAP_VEC` constants.
- Sub-module `pc_next_sel`: combinational next-PC mux (target/pend/+4) plus misalignment check.

## Test plan
- Reset then zero-wait memory, `stall`=0: addresses 0x0, 0x4, 0x8 are fetched; `if_pc` follows the same sequence, one instruction per 2 cycles.
- `imem_ack` delayed 3 cycles: `imem_addr` stays 0x4 throughout; `if_instr` matches `imem_rdata` on the ack cycle.
- `stall` high for 4 cycles in HOLD: `if_valid`/`if_pc`/`if_instr` unchanged and `imem_req`=0; fetch resumes after release.
- Redirect to 0x200 while FETCH waits, ack 2 cycles later: the first response is discarded, the next `imem_addr`=0x200, and `if_pc`=0x200.
- Redirect to 0x302 with the macro defined: pc=0x100 and `misalign_trap` pulses once. Without the macro: pc=0x300 and no trap.
- pc=0xFFFF_FFFC fetch ack: the next `imem_addr` is 0x0000_0000; `rst` asserted mid-DRAIN returns to IDLE with `imem_addr`=`RESET_VEC`.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, next-PC
// select codes and default vectors.
package pc_fetch_pkg;

  localparam int unsigned INSTR_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_KEEP = 2'd0,
    PC_SEL_INC  = 2'd1,
    PC_SEL_TGT  = 2'd2,
    PC_SEL_PEND = 2'd3
  } pc_sel_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Combinational next-PC mux (keep / +4 / redirect target / pending target)
// with redirect sanitising; PC_FETCH_MISALIGN_CHECK_EN selects trap vs. mask.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic [31:0] pc,
  input  logic [31:0] pend,
  input  logic [31:0] redirect_target,
  input  pc_sel_e     sel,
  output logic [31:0] target_eff,
  output logic [31:0] next_pc,
  output logic        misaligned
);

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(redirect_target);
  assign target_eff = misaligned ? TRAP_VEC : redirect_target;
`else
  // Low target bits are dropped, so they and the trap vector are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{redirect_target[1:0], TRAP_VEC};
  assign misaligned  = 1'b0;
  assign target_eff  = {redirect_target[31:2], 2'b00};
`endif

  always_comb begin
    next_pc = pc;
    case (sel)
      PC_SEL_KEEP: next_pc = pc;
      PC_SEL_INC:  next_pc = pc + 32'(INSTR_BYTES);
      PC_SEL_TGT:  next_pc = target_eff;
      PC_SEL_PEND: next_pc = pend;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction-memory requests and feeds
// decode through a one-entry buffer. Optional feature: PC_FETCH_MISALIGN_CHECK_EN.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  input  logic         stall,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_instr,
  output logic         misalign_trap,
  output fetch_state_e dbg_state
);

  // Handshakes: imem_req/imem_addr come only from registered state and pc;
  // once imem_req is high the address holds until imem_ack is sampled high
  // (ack may arrive in the request cycle). Decode consumes when if_valid && !stall.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         trap_q, trap_d;

  pc_sel_e      pc_sel;
  logic [31:0]  target_eff;
  logic         misaligned;
  logic         consume;

  pc_next_sel #(
    .TRAP_VEC(TRAP_VEC)
  ) u_pc_next_sel (
    .pc              (pc_q),
    .pend            (pend_q),
    .redirect_target (redirect_target),
    .sel             (pc_sel),
    .target_eff      (target_eff),
    .next_pc         (pc_d),
    .misaligned      (misaligned)
  );

  assign consume = if_valid_q && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      pend_q     <= 32'h0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      trap_q     <= trap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pc_sel     = PC_SEL_KEEP;
    trap_d     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_ack && redirect_valid) begin
          pc_sel = PC_SEL_TGT;
        end else if (imem_ack) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          pc_sel     = PC_SEL_INC;
          state_d    = ST_HOLD;
        end else if (redirect_valid) begin
          // Address must stay put until the outstanding response returns.
          pend_d  = target_eff;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) pend_d = target_eff;
        if (imem_ack) begin
          pc_sel  = redirect_valid ? PC_SEL_TGT : PC_SEL_PEND;
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_sel     = PC_SEL_TGT;
          state_d    = ST_FETCH;
        end else if (consume) begin
          if_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && redirect_valid && misaligned) trap_d = 1'b1;
  end

  assign imem_req      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr     = pc_q;
  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign misalign_trap = trap_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic checked by a
// program-order scoreboard. Honours PC_FETCH_MISALIGN_CHECK_EN.
module tb_pc_fetch_ctrl;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_target = 32'h0;
  logic         stall = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic         if_valid;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         misalign_trap;
  fetch_state_e dbg_state;

  pc_fetch_ctrl #(.RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .misalign_trap   (misalign_trap),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic trap_pend = 1'b0;
  int ack_min = 0, ack_max = 0;
  int wait_cnt = 0, cur_delay = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    if (t[1:0] != 2'b00) return TV;
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  always begin
    @(negedge clk);
    #1;
    if (imem_req) begin
      if (wait_cnt >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
        cur_delay  = $urandom_range(ack_max, ack_min);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wait_cnt   = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // Model: delivered instructions follow program order from the last reset
  // vector or effective redirect target, advancing by 4 per delivery.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = 32'h0;

  always begin
    logic [31:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RV);
      trap_pend = 1'b0;
    end else begin
      check_bit("misalign_trap", misalign_trap, trap_pend);
      check_bit("req_while_buffered", imem_req & if_valid, 1'b0);
      if (!prev_rst && prev_req && !prev_ack) begin
        check_bit("req_held", imem_req, 1'b1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (if_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got pc %h expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_if_pc", if_pc, e);
          check("sb_if_instr", if_instr, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
      end
      trap_pend = 1'b0;
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(eff_target(redirect_target));
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        trap_pend = (redirect_target[1:0] != 2'b00);
`endif
      end
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    prev_rst  = rst;
  end

  // ---------------- driver tasks ----------------
  // Inputs change at negedge+1; outputs of the current cycle are checked at +3.
  task automatic tick(input logic r, input logic s, input logic rv, input logic [31:0] t);
    @(negedge clk);
    #1;
    rst = r; stall = s; redirect_valid = rv; redirect_target = t;
    #2;
  endtask

  task automatic do_reset(input int dly);
    ack_min = dly; ack_max = dly; cur_delay = dly;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic        zw_req[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] zw_val[6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};

  initial begin
    int k;
    logic s, rv;
    logic [31:0] t;

    // Reset values, then zero-wait sequential fetch with a 4-cycle stall in HOLD.
    do_reset(0);
    check_bit("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, RV);
    check_bit("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check_bit("rst_misalign_trap", misalign_trap, 1'b0);
    check_bit("rst_state_idle", dbg_state == ST_IDLE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, i == 5, 1'b0, 32'h0);
      check_bit("zw_req", imem_req, zw_req[i]);
      if (zw_req[i]) check("zw_addr", imem_addr, zw_val[i]);
      else begin
        check_bit("zw_if_valid", if_valid, 1'b1);
        check("zw_if_pc", if_pc, zw_val[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, i < 3, 1'b0, 32'h0);
      check_bit("stall_if_valid", if_valid, 1'b1);
      check("stall_if_pc", if_pc, 32'h8);
      check("stall_if_instr", if_instr, mem_word(32'h8));
      check_bit("stall_req", imem_req, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, 32'hC);

    // Three wait states on every response.
    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (i >= 5 && i <= 8) begin
        check_bit("wait_req", imem_req, 1'b1);
        check("wait_addr", imem_addr, 32'h4);
      end
    end
    check_bit("wait_if_valid", if_valid, 1'b1);
    check("wait_if_pc", if_pc, 32'h4);
    check("wait_if_instr", if_instr, mem_word(32'h4));

    // Redirect while FETCH waits: old response drained, then fetch from 0x200.
    do_reset(2);
    tick(1'b0, 1'b0, 1'b1, 32'h200);
    check("rd_addr_c2", imem_addr, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("rd_drain_req", imem_req, 1'b1);
    check("rd_drain_addr", imem_addr, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_drain_addr2", imem_addr, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("rd_new_req", imem_req, 1'b1);
    check("rd_new_addr", imem_addr, 32'h200);
    k = 0;
    while (!if_valid && k < 20) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      k++;
    end
    if (!if_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rd_timeout: got no if_valid expected delivery within 20 cycles");
    end else begin
      check("rd_if_pc", if_pc, 32'h200);
      check("rd_if_instr", if_instr, mem_word(32'h200));
    end

    // Reset asserted in DRAIN.
    do_reset(3);
    tick(1'b0, 1'b0, 1'b1, 32'h400);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check_bit("mid_drain_state", dbg_state == ST_DRAIN, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_addr", imem_addr, RV);
    check_bit("mid_rst_if_valid", if_valid, 1'b0);

    // Misaligned redirect from HOLD.
    do_reset(0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h302);
    check_bit("mis_hold", if_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    check("mis_addr", imem_addr, 32'h100);
    check_bit("mis_trap", misalign_trap, 1'b1);
`else
    check("mis_addr", imem_addr, 32'h300);
    check_bit("mis_trap", misalign_trap, 1'b0);
`endif
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("mis_trap_once", misalign_trap, 1'b0);

    // PC wrap at the top of the address space.
    do_reset(0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("wrap_req", imem_req, 1'b1);
    check("wrap_addr_zero", imem_addr, 32'h0);

    // Random traffic: stalls, redirects (some misaligned) and 0-3 wait states.
    do_reset(0);
    ack_max = 3;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 2) == 0);
      rv = (i > 0) && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) t = $urandom;
      else t = {20'h0, 12'($urandom_range(0, 4095))};
      tick(1'b0, s, rv, t);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
